// File: rtl/mux_scan_sequencer.sv
// Break-before-make sequencer for the 2-to-4 switch decoder and the 4:1 analog output mux.
// Scan mode round-robins over ch_mask; manual mode routes one channel per valid/ready request.
module mux_scan_sequencer #(
    parameter int GUARD   = 2,
    parameter int SETTLE  = 3,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               mode,
    input  logic [3:0]         ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               req_valid,
    input  logic [1:0]         req_ch,
    output logic               req_ready,
    output logic               sel_a,
    output logic               sel_b,
    output logic [1:0]         mux_sel,
    output logic               sw_en,
    output logic               settled,
    output logic               sample,
    output logic [1:0]         cur_ch,
    output logic               busy
);

    // state  | meaning
    // IDLE   | switches open, waiting for scan start or manual request
    // BREAK  | switches open for GUARD cycles, selects already at target
    // SETTLE | switch closed, output not yet settled
    // DWELL  | output settled, sample strobe on the last cycle
    // HOLD   | manual channel held closed, waiting for the next request
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] BREAK  = 3'd1;
    localparam logic [2:0] SETTLE_ST = 3'd2;
    localparam logic [2:0] DWELL  = 3'd3;
    localparam logic [2:0] HOLD   = 3'd4;

    localparam int GS_W  = $clog2(GUARD + SETTLE + 1);
    localparam int CNT_W = (DWELL_W > GS_W) ? DWELL_W : GS_W;
    localparam logic [CNT_W-1:0] GUARD_LD  = CNT_W'(GUARD - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cur_ch_q, cur_ch_d;
    logic [1:0]       ptr_q, ptr_d;
    logic             req_ready_q, req_ready_d;
    logic             sw_en_q, sw_en_d;
    logic             settled_q, settled_d;
    logic             sample_q, sample_d;
    logic             busy_q, busy_d;
    logic [1:0]       tgt;
    logic [CNT_W-1:0] dwell_ld;
    logic             accept;

    // First enabled channel after ptr, wrapping 3->0; ptr itself is the last candidate.
    function automatic logic [1:0] next_ch(input logic [1:0] ptr, input logic [3:0] mask);
        logic [1:0] idx;
        next_ch = ptr;
        for (int i = 3; i >= 1; i--) begin
            idx = ptr + 2'(i);
            if (mask[idx]) next_ch = idx;
        end
    endfunction

    assign tgt      = next_ch(ptr_q, ch_mask);
    assign dwell_ld = (dwell == '0) ? '0 : CNT_W'(dwell) - ONE;
    assign accept   = req_valid & req_ready_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cur_ch_d = cur_ch_q;
        ptr_d    = ptr_q;
        if (!ena) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!mode && ch_mask != '0) begin
                        state_d  = BREAK;
                        cnt_d    = GUARD_LD;
                        cur_ch_d = tgt;
                        ptr_d    = tgt;
                    end else if (mode && accept) begin
                        state_d  = BREAK;
                        cnt_d    = GUARD_LD;
                        cur_ch_d = req_ch;
                    end
                end
                BREAK: begin
                    if (cnt_q == '0) begin
                        state_d = SETTLE_ST;
                        cnt_d   = SETTLE_LD;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                SETTLE_ST: begin
                    if (cnt_q == '0) begin
                        state_d = DWELL;
                        cnt_d   = dwell_ld;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                DWELL: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - ONE;
                    end else if (mode) begin
                        state_d = HOLD;
                    end else if (ch_mask == '0) begin
                        state_d = IDLE;
                    end else if (tgt == cur_ch_q) begin
                        cnt_d = dwell_ld;
                    end else begin
                        state_d  = BREAK;
                        cnt_d    = GUARD_LD;
                        cur_ch_d = tgt;
                        ptr_d    = tgt;
                    end
                end
                HOLD: begin
                    if (!mode) begin
                        state_d = IDLE;
                    end else if (accept) begin
                        if (req_ch == cur_ch_q) begin
                            state_d = DWELL;
                            cnt_d   = dwell_ld;
                        end else begin
                            state_d  = BREAK;
                            cnt_d    = GUARD_LD;
                            cur_ch_d = req_ch;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        sw_en_d     = (state_d == SETTLE_ST) || (state_d == DWELL) || (state_d == HOLD);
        settled_d   = (state_d == DWELL) || (state_d == HOLD);
        sample_d    = (state_d == DWELL) && (cnt_d == '0);
        busy_d      = (state_d != IDLE);
        req_ready_d = (state_d == HOLD) || ((state_d == IDLE) && ena && mode);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cur_ch_q    <= 2'd0;
            ptr_q       <= 2'd3;
            req_ready_q <= 1'b0;
            sw_en_q     <= 1'b0;
            settled_q   <= 1'b0;
            sample_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_ch_q    <= cur_ch_d;
            ptr_q       <= ptr_d;
            req_ready_q <= req_ready_d;
            sw_en_q     <= sw_en_d;
            settled_q   <= settled_d;
            sample_q    <= sample_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign sel_a     = cur_ch_q[1];
    assign sel_b     = cur_ch_q[0];
    assign mux_sel   = cur_ch_q;
    assign cur_ch    = cur_ch_q;
    assign sw_en     = sw_en_q;
    assign settled   = settled_q;
    assign sample    = sample_q;
    assign busy      = busy_q;

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Sequences the 2-to-4 switch decoder and the 4:1 analog output mux so one of four channels is routed to the single analog output at a time.
- Scan mode: round-robins over a channel mask. Manual mode: one channel per request, via a valid/ready handshake.
- Enforces break-before-make: all switches open, select lines change, settle time, then a timed dwell window with a sample strobe.
- Sits beside the decoder/mux pair in the top-level wrapper and drives their select pins.

Parameters:
- GUARD, 2, cycles with all switches open (sw_en=0) before a new channel closes; minimum 1.
- SETTLE, 3, cycles after switch closure before the output counts as settled; minimum 1.
- DWELL_W, 8, width of the dwell input.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous reset, active-low.
- ena  input  1  sequencer enable.
- mode  input  1  0 = scan, 1 = manual.
- ch_mask  input  4  channels taking part in the scan (bit i = channel i).
- dwell  input  DWELL_W  dwell length in cycles; 0 is treated as 1.
- req_valid  input  1  manual request valid.
- req_ch  input  2  requested channel.
- req_ready  output  1  manual request accepted this cycle when req_valid is also high.
- sel_a  output  1  decoder input a = cur_ch[1].
- sel_b  output  1  decoder input b = cur_ch[0].
- mux_sel  output  2  output mux select = cur_ch.
- sw_en  output  1  switch gate; 0 forces all decoder outputs open.
- settled  output  1  high during DWELL.
- sample  output  1  one-cycle pulse on the last DWELL cycle.
- cur_ch  output  2  currently routed channel.
- busy  output  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, cur_ch=0, sel_a=sel_b=0, mux_sel=0, sw_en=0, settled=0, sample=0, req_ready=0, busy=0. The round-robin pointer resets to 3, so the first scan selects the lowest enabled channel.
- States: IDLE, BREAK, SETTLE, DWELL, HOLD.
- IDLE
  - sw_en=0.
  - req_ready=1 when mode=1 and ena=1.
  - Scan start: ena=1, mode=0 and ch_mask!=0 -> BREAK. Target = first mask bit after the pointer, searching upward and wrapping 3->0.
  - Manual start: ena=1, mode=1 and req_valid=1 -> BREAK with target req_ch.
- BREAK
  - sw_en=0 for exactly GUARD cycles.
  - cur_ch, sel_a, sel_b and mux_sel take the target value in the first BREAK cycle. Selects never change while sw_en=1.
  - Then -> SETTLE.
- SETTLE
  - sw_en=1, settled=0, for exactly SETTLE cycles.
  - Then -> DWELL.
- DWELL
  - sw_en=1, settled=1, for max(dwell,1) cycles. dwell is latched on DWELL entry.
  - sample=1 on the last DWELL cycle.
  - Decision on the last cycle, scan mode: recompute the next target from the current ch_mask. If the target equals cur_ch, re-enter DWELL with no break. If it differs, -> BREAK. If the mask is 0, -> IDLE.
  - Decision on the last cycle, manual mode: -> HOLD.
- HOLD (manual only)
  - sw_en=1, settled=1, req_ready=1.
  - Accepted request with req_ch==cur_ch -> DWELL directly (no break, no settle).
  - Accepted request with any other channel -> BREAK.
  - mode=0 -> IDLE.
- Handshake: a request is accepted only on a cycle where req_valid & req_ready. req_ready=0 in BREAK, SETTLE and DWELL, so requests wait.
- mode and ch_mask are sampled only at decision points (IDLE, last DWELL cycle, HOLD). Changes mid-window take effect at the next decision.
- ena=0 in any state -> IDLE on the next edge. sw_en falls that edge; select lines keep their last value; no sample is issued.
- A mid-operation rst_n assertion forces reset values immediately, asynchronously.
- busy=1 in BREAK, SETTLE, DWELL and HOLD.

Test Plan:
- Reset, then ena=1, mode=0, ch_mask=4'b1111, dwell=4, GUARD=2, SETTLE=3 -> cur_ch goes 0,1,2,3,0. Each channel: 2 cycles sw_en=0, 3 settling, 4 settled. Each slot is 9 cycles with one sample pulse. sw_en is never 1 on a select-change edge.
- ch_mask=4'b0100, dwell=2 -> a single BREAK/SETTLE into channel 2, then repeated 2-cycle DWELLs with sample every 2nd cycle and sw_en held 1.
- ch_mask=4'b1010, dwell=0 -> channels alternate 1,3,1; each DWELL is 1 cycle with sample=1.
- mode=1, req_valid=1, req_ch=2 in IDLE -> req_ready=1 that cycle, then BREAK to channel 2, then HOLD.
  - Second request req_ch=2 -> DWELL directly.
  - req_ch=0 in HOLD -> BREAK, with cur_ch=0 in the first BREAK cycle.
- ena dropped in the 2nd SETTLE cycle -> next cycle IDLE, sw_en=0, busy=0, no sample; cur_ch unchanged.
- rst_n pulsed low mid-DWELL, between clock edges -> all outputs at reset values without waiting for clk. Restart selects the lowest enabled channel.
